// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, ALU codes,
// data-processing commands, condition codes and datapath mux selects.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BRANCH
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  // flags = {N,Z,C,V}; the reserved code 1111 never executes
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    {n, z, c, v} = flags;
    case (cond)
      COND_EQ: cond_eval = z;
      COND_NE: cond_eval = !z;
      COND_CS: cond_eval = c;
      COND_CC: cond_eval = !c;
      COND_MI: cond_eval = n;
      COND_PL: cond_eval = !n;
      COND_VS: cond_eval = v;
      COND_VC: cond_eval = !v;
      COND_HI: cond_eval = c & !z;
      COND_LS: cond_eval = !c | z;
      COND_GE: cond_eval = (n == v);
      COND_LT: cond_eval = (n != v);
      COND_GT: cond_eval = !z & (n == v);
      COND_LE: cond_eval = z | (n != v);
      COND_AL: cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
    case (cmd)
      CMD_ADD: alu_decode = ALU_ADD;
      CMD_SUB: alu_decode = ALU_SUB;
      CMD_CMP: alu_decode = ALU_SUB;
      CMD_AND: alu_decode = ALU_AND;
      CMD_ORR: alu_decode = ALU_ORR;
      default: alu_decode = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_if.sv
// Control-unit to datapath bundle. The control unit owns the master side;
// the datapath (or a bench standing in for it) uses the slave side.
interface ctrl_if;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic [1:0]  AluControl;
  logic        PCWrite;
  logic        IRWrite;
  logic        RegWrite;
  logic        MemWrite;
  logic        AdrSrc;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ResultSrc;
  logic [1:0]  ImmSrc;
  logic [1:0]  RegSrc;
  logic [3:0]  Flags;

  modport master (
    input  Instr, ALUFlags,
    output AluControl, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, Flags
  );

  modport slave (
    output Instr, ALUFlags,
    input  AluControl, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc,
           ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, Flags
  );
endinterface

// File: rtl/cond_logic_module.sv
// Architectural NZCV register plus the condition-pass latch captured in DECODE,
// which gates every write for the rest of the instruction.
module cond_logic_module
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       flag_en,
  input  logic       decode_strobe,
  output logic       CondEx_q,
  output logic [3:0] Flags
);

  logic [3:0] flags_reg;
  logic       cond_q_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_reg  <= 4'b0000;
      cond_q_reg <= 1'b0;
    end else begin
      if (decode_strobe)
        cond_q_reg <= cond_eval(Cond, flags_reg);
      // FlagW[1] covers N,Z and FlagW[0] covers C,V
      if (flag_en && cond_q_reg && FlagW[1])
        flags_reg[3:2] <= ALUFlags[3:2];
      if (flag_en && cond_q_reg && FlagW[0])
        flags_reg[1:0] <= ALUFlags[1:0];
    end
  end

  assign CondEx_q = cond_q_reg;
  assign Flags    = flags_reg;

endmodule

// File: rtl/control_unit_module.sv
// Multicycle Moore control FSM with ALU decoder; outputs decode from the
// registered state, with write strobes held low while reset is asserted.
module control_unit_module
  import ctrl_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  ctrl_if.master   bus
);

  state_t     state_reg, state_next;
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] cmd;
  logic       s_bit, is_cmp, is_add, is_sub, rd_is_pc;
  logic [1:0] flag_w;
  logic       cond_q, flag_en, decode_strobe;
  logic       pc_w, ir_w, reg_w, mem_w, adr_src, src_a;
  logic [1:0] alu_ctrl, src_b, res_src;
  logic       unused_rn_bits;

  assign cond  = bus.Instr[19:16];
  assign op    = bus.Instr[15:14];
  assign funct = bus.Instr[13:8];
  assign rd    = bus.Instr[3:0];
  assign unused_rn_bits = ^bus.Instr[7:4];

  assign cmd      = funct[4:1];
  assign s_bit    = funct[0];
  assign is_cmp   = (cmd == CMD_CMP);
  assign is_add   = (cmd == CMD_ADD);
  assign is_sub   = (cmd == CMD_SUB);
  assign rd_is_pc = (rd == 4'hF);
  assign flag_w   = {s_bit | is_cmp, (s_bit & (is_add | is_sub)) | is_cmp};

  cond_logic_module u_cond (
    .clk           (clk),
    .rst_n         (rst_n),
    .Cond          (cond),
    .ALUFlags      (bus.ALUFlags),
    .FlagW         (flag_w),
    .flag_en       (flag_en),
    .decode_strobe (decode_strobe),
    .CondEx_q      (cond_q),
    .Flags         (bus.Flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_FETCH;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next    = state_reg;
    alu_ctrl      = ALU_ADD;
    pc_w          = 1'b0;
    ir_w          = 1'b0;
    reg_w         = 1'b0;
    mem_w         = 1'b0;
    adr_src       = 1'b0;
    src_a         = 1'b0;
    src_b         = SRCB_REG;
    res_src       = RES_ALUOUT;
    flag_en       = 1'b0;
    decode_strobe = 1'b0;
    case (state_reg)
      S_FETCH: begin
        ir_w = 1'b1; pc_w = 1'b1; src_a = 1'b1; src_b = SRCB_FOUR; res_src = RES_ALURES;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        src_a = 1'b1; src_b = SRCB_FOUR; res_src = RES_ALURES; decode_strobe = 1'b1;
        case (op)
          2'b01:   state_next = S_MEMADR;
          2'b00:   state_next = funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b10:   state_next = S_BRANCH;
          default: state_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        src_b = SRCB_IMM;
        state_next = funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        res_src = RES_RDATA;
        if (rd_is_pc) pc_w = cond_q; else reg_w = cond_q;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1; mem_w = cond_q;
        state_next = S_FETCH;
      end
      S_EXECUTER, S_EXECUTEI: begin
        src_b    = (state_reg == S_EXECUTEI) ? SRCB_IMM : SRCB_REG;
        alu_ctrl = alu_decode(cmd);
        flag_en  = 1'b1;
        state_next = is_cmp ? S_FETCH : S_ALUWB;
      end
      S_ALUWB: begin
        res_src = RES_ALUOUT;
        if (rd_is_pc) pc_w = cond_q; else reg_w = cond_q;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        src_b = SRCB_IMM; res_src = RES_ALURES; pc_w = cond_q;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // strobes are gated by the reset pin so nothing is emitted while it is low
  assign bus.PCWrite    = pc_w  & rst_n;
  assign bus.IRWrite    = ir_w  & rst_n;
  assign bus.RegWrite   = reg_w & rst_n;
  assign bus.MemWrite   = mem_w & rst_n;
  assign bus.AluControl = alu_ctrl;
  assign bus.AdrSrc     = adr_src;
  assign bus.ALUSrcA    = src_a;
  assign bus.ALUSrcB    = src_b;
  assign bus.ResultSrc  = res_src;
  assign bus.ImmSrc     = op;
  assign bus.RegSrc     = {op == 2'b01, op == 2'b10};

endmodule

// File: tb/tb_control_unit_module.sv
// Directed bench for control_unit_module: per-cycle control words and flag
// register contents are compared against hand-derived vectors.
module tb_control_unit_module;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ctrl_if bus ();

  control_unit_module dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // control word = {AluControl, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}
  logic [11:0] ctrl_word;
  assign ctrl_word = {bus.AluControl, bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite,
                      bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc};

  localparam logic [11:0] V_FETCH  = 12'b00_1_1_0_0_0_1_10_10;
  localparam logic [11:0] V_DECODE = 12'b00_0_0_0_0_0_1_10_10;
  localparam logic [11:0] V_RESET  = 12'b00_0_0_0_0_0_1_10_10;
  localparam logic [11:0] V_IDLE   = 12'b00_0_0_0_0_0_0_00_00;

  logic [11:0] got [8];

  function automatic logic [19:0] mk(input logic [3:0] c, input logic [1:0] o,
                                     input logic [5:0] f, input logic [3:0] r);
    mk = {c, o, f, 4'b0000, r};
  endfunction

  // drive one instruction and record the control word of each of its n cycles
  task automatic run(input logic [19:0] ins, input logic [3:0] af, input int n);
    bus.Instr = ins;
    bus.ALUFlags = af;
    for (int i = 0; i < n; i++) begin
      #1 got[i] = ctrl_word;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bus.Instr = 20'h0;
    bus.ALUFlags = 4'h0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (ctrl_word !== V_RESET) begin
      miscompares++; $display("FAIL reset_ctrl: got %b expected %b", ctrl_word, V_RESET);
    end
    vectors++;
    if (bus.Flags !== 4'b0000) begin
      miscompares++; $display("FAIL reset_flags: got %b expected 0000", bus.Flags);
    end
    rst_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_add();
    logic [11:0] e [4];
    e = '{V_FETCH, V_DECODE, 12'b00_0_0_0_0_0_0_00_00, 12'b00_0_0_1_0_0_0_00_00};
    run(mk(4'b1110, 2'b00, 6'b001000, 4'b0001), 4'b1111, 4);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (got[i] !== e[i]) begin
        miscompares++; $display("FAIL add cycle %0d: got %b expected %b", i, got[i], e[i]);
      end
    end
    vectors++;
    if (bus.Flags !== 4'b0000) begin
      miscompares++; $display("FAIL add_flags: got %b expected 0000", bus.Flags);
    end
    $display("ADD r1 done, flags %b", bus.Flags);
  endtask

  task automatic test_cmp();
    logic [11:0] e [3];
    e = '{V_FETCH, V_DECODE, 12'b01_0_0_0_0_0_0_00_00};
    run(mk(4'b1110, 2'b00, 6'b010101, 4'b0000), 4'b0100, 3);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (got[i] !== e[i]) begin
        miscompares++; $display("FAIL cmp cycle %0d: got %b expected %b", i, got[i], e[i]);
      end
    end
    vectors++;
    if (bus.Flags !== 4'b0100) begin
      miscompares++; $display("FAIL cmp_flags: got %b expected 0100", bus.Flags);
    end
    $display("CMP done, flags %b", bus.Flags);
  endtask

  task automatic test_branch(input logic taken);
    logic [11:0] e [3];
    e = '{V_FETCH, V_DECODE, taken ? 12'b00_1_0_0_0_0_0_01_10 : 12'b00_0_0_0_0_0_0_01_10};
    run(mk(4'b0000, 2'b10, 6'b000000, 4'b0000), 4'b0000, 3);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (got[i] !== e[i]) begin
        miscompares++; $display("FAIL beq(taken=%0d) cycle %0d: got %b expected %b", taken, i, got[i], e[i]);
      end
    end
    vectors++;
    if ({bus.ImmSrc, bus.RegSrc} !== 4'b10_01) begin
      miscompares++; $display("FAIL beq_imm_regsrc: got %b expected 1001", {bus.ImmSrc, bus.RegSrc});
    end
    $display("BEQ done, expected taken=%0d", taken);
  endtask

  task automatic test_subs();
    logic [11:0] e [4];
    e = '{V_FETCH, V_DECODE, 12'b01_0_0_0_0_0_0_00_00, 12'b00_0_0_1_0_0_0_00_00};
    run(mk(4'b1110, 2'b00, 6'b000101, 4'b0010), 4'b0000, 4);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (got[i] !== e[i]) begin
        miscompares++; $display("FAIL subs cycle %0d: got %b expected %b", i, got[i], e[i]);
      end
    end
    vectors++;
    if (bus.Flags !== 4'b0000) begin
      miscompares++; $display("FAIL subs_flags: got %b expected 0000", bus.Flags);
    end
    $display("SUBS r2 done, flags %b", bus.Flags);
  endtask

  task automatic test_ldr();
    logic [11:0] e [5];
    e = '{V_FETCH, V_DECODE, 12'b00_0_0_0_0_0_0_01_00, 12'b00_0_0_0_0_1_0_00_00,
          12'b00_0_0_1_0_0_0_00_01};
    run(mk(4'b1110, 2'b01, 6'b011001, 4'b0011), 4'b0000, 5);
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (got[i] !== e[i]) begin
        miscompares++; $display("FAIL ldr cycle %0d: got %b expected %b", i, got[i], e[i]);
      end
    end
    vectors++;
    if ({bus.ImmSrc, bus.RegSrc} !== 4'b01_10) begin
      miscompares++; $display("FAIL ldr_imm_regsrc: got %b expected 0110", {bus.ImmSrc, bus.RegSrc});
    end
    $display("LDR r3 done");
  endtask

  task automatic test_str();
    logic [11:0] e [4];
    e = '{V_FETCH, V_DECODE, 12'b00_0_0_0_0_0_0_01_00, 12'b00_0_0_0_1_1_0_00_00};
    run(mk(4'b1110, 2'b01, 6'b011000, 4'b0011), 4'b0000, 4);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (got[i] !== e[i]) begin
        miscompares++; $display("FAIL str cycle %0d: got %b expected %b", i, got[i], e[i]);
      end
    end
    $display("STR r3 done");
  endtask

  task automatic test_adds_imm();
    logic [11:0] e [4];
    e = '{V_FETCH, V_DECODE, 12'b00_0_0_0_0_0_0_01_00, 12'b00_0_0_1_0_0_0_00_00};
    run(mk(4'b1110, 2'b00, 6'b101001, 4'b0100), 4'b0011, 4);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (got[i] !== e[i]) begin
        miscompares++; $display("FAIL adds_imm cycle %0d: got %b expected %b", i, got[i], e[i]);
      end
    end
    vectors++;
    if (bus.Flags !== 4'b0011) begin
      miscompares++; $display("FAIL adds_imm_flags: got %b expected 0011", bus.Flags);
    end
    $display("ADDS imm r4 done, flags %b", bus.Flags);
  endtask

  task automatic test_orrs_pc();
    logic [11:0] e [4];
    e = '{V_FETCH, V_DECODE, 12'b11_0_0_0_0_0_0_00_00, 12'b00_1_0_0_0_0_0_00_00};
    run(mk(4'b1110, 2'b00, 6'b011001, 4'b1111), 4'b1000, 4);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (got[i] !== e[i]) begin
        miscompares++; $display("FAIL orrs_pc cycle %0d: got %b expected %b", i, got[i], e[i]);
      end
    end
    vectors++;
    if (bus.Flags !== 4'b1011) begin
      miscompares++; $display("FAIL orrs_flags: got %b expected 1011", bus.Flags);
    end
    $display("ORRS pc done, flags %b", bus.Flags);
  endtask

  task automatic test_cond_fail();
    logic [11:0] e [4];
    e = '{V_FETCH, V_DECODE, 12'b00_0_0_0_0_0_0_00_00, V_IDLE};
    run(mk(4'b0000, 2'b00, 6'b001001, 4'b0101), 4'b0100, 4);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (got[i] !== e[i]) begin
        miscompares++; $display("FAIL addseq_fail cycle %0d: got %b expected %b", i, got[i], e[i]);
      end
    end
    vectors++;
    if (bus.Flags !== 4'b1011) begin
      miscompares++; $display("FAIL addseq_flags: got %b expected 1011", bus.Flags);
    end
    $display("ADDSEQ (failing) done, flags %b", bus.Flags);
  endtask

  task automatic test_undefined();
    logic [11:0] e [2];
    e = '{V_FETCH, V_DECODE};
    run(mk(4'b1110, 2'b11, 6'b000000, 4'b0001), 4'b0000, 2);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (got[i] !== e[i]) begin
        miscompares++; $display("FAIL undef cycle %0d: got %b expected %b", i, got[i], e[i]);
      end
    end
    $display("undefined op done");
  endtask

  task automatic test_reset_in_memwrite();
    run(mk(4'b1110, 2'b01, 6'b011000, 4'b0011), 4'b0000, 3);
    #1;
    vectors++;
    if (ctrl_word !== 12'b00_0_0_0_1_1_0_00_00) begin
      miscompares++; $display("FAIL memwrite_before_rst: got %b expected 000001100000", ctrl_word);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.MemWrite !== 1'b0) begin
      miscompares++; $display("FAIL memwrite_async_drop: got %b expected 0", bus.MemWrite);
    end
    vectors++;
    if (ctrl_word !== V_RESET) begin
      miscompares++; $display("FAIL rst_mid_ctrl: got %b expected %b", ctrl_word, V_RESET);
    end
    vectors++;
    if (bus.Flags !== 4'b0000) begin
      miscompares++; $display("FAIL rst_mid_flags: got %b expected 0000", bus.Flags);
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset pulsed during MEMWRITE");
  endtask

  initial begin
    test_reset();
    test_add();
    test_cmp();
    test_branch(1'b1);
    test_subs();
    test_branch(1'b0);
    test_ldr();
    test_str();
    test_adds_imm();
    test_orrs_pc();
    test_cond_fail();
    test_undefined();
    test_reset_in_memwrite();
    test_add();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/control_unit_module.md
# control_unit_module

Multicycle control unit that drives the 32-bit ALU and datapath. It decodes the instruction fields, sequences each instruction through a Moore FSM and issues the ALU's `AluControl` code. It also closes the loop on the ALU's `ALUFlags` output by holding an architectural NZCV flag register and gating every architectural write on the instruction's condition field.

## Interface
Parameters: none; all encodings come from `ctrl_pkg`.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `Instr`  in  20  instruction bits [31:12]:
  - Cond = [31:28]
  - Op = [27:26]
  - Funct = [25:20]
  - Rd = [15:12]
- `ALUFlags`  in  4  {N,Z,C,V} from the ALU, valid combinationally in EXECUTE states.
- `AluControl`  out  2  ALU operation: 00 add, 01 sub, 10 and, 11 or.
- `PCWrite`, `IRWrite`, `RegWrite`, `MemWrite`  out  1 each  write strobes.
- `AdrSrc`  out  1  memory address select: 0 = PC, 1 = Result.
- `ALUSrcA`  out  1  0 = register A, 1 = PC.
- `ALUSrcB`  out  2  00 = register B, 01 = extended immediate, 10 = constant 4.
- `ResultSrc`  out  2  00 = ALUOut, 01 = read data, 10 = ALUResult.
- `ImmSrc`  out  2  equals Op.
- `RegSrc`  out  2  [0] = (Op==10), [1] = (Op==01).
- `Flags`  out  4  current flag register {N,Z,C,V}.

## Operation
FSM states and outputs. Every output not listed for a state is 0, and AluControl defaults to add.
- FETCH: IRWrite=1, PCWrite=1 (unconditional), ALUSrcA=1, ALUSrcB=10, ResultSrc=10. Next: DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. Latch cond_q = CondEx. Next state by Op and Funct:
  - Op=01 → MEMADR
  - Op=00 with Funct[5]=0 → EXECUTER
  - Op=00 with Funct[5]=1 → EXECUTEI
  - Op=10 → BRANCH
  - Op=11 → FETCH (undefined instruction; no side effects)
- MEMADR: ALUSrcB=01. Next: MEMREAD if Funct[0]=1, else MEMWRITE.
- MEMREAD: AdrSrc=1. Next: MEMWB.
- MEMWB: ResultSrc=01; write back per the Rd rule below. Next: FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=cond_q. Next: FETCH.
- EXECUTER (ALUSrcB=00) and EXECUTEI (ALUSrcB=01): AluControl decoded from cmd = Funct[4:1]:
  - 0100 ADD → 00
  - 0010 SUB → 01
  - 1010 CMP → 01
  - 0000 AND → 10
  - 1100 ORR → 11
  - any other cmd → 00
  - Next: FETCH for CMP, else ALUWB.
- ALUWB: ResultSrc=00; write back per the Rd rule below. Next: FETCH.
- BRANCH: ALUSrcB=01, ResultSrc=10, PCWrite=cond_q. Next: FETCH.
- Rd rule in ALUWB/MEMWB:
  - Rd=1111: PCWrite=cond_q, RegWrite=0.
  - Otherwise: RegWrite=cond_q.

Flag writes:
- FlagW[1] (N,Z) = Funct[0] (S bit).
- FlagW[0] (C,V) = S & (ADD|SUB|CMP). CMP always writes both, regardless of S.
- At the clock edge ending an EXECUTE state with cond_q=1:
  - FlagW[1] loads N,Z from ALUFlags[3:2].
  - FlagW[0] loads C,V from ALUFlags[1:0].

CondEx is computed from the flag register:
- EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
- HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
- AL 1; Cond=1111 → 0.

## Timing
- Reset (rst_n low, async): state=FETCH, flags=0000, cond_q=0.
  - PCWrite, IRWrite, RegWrite and MemWrite are forced to 0 while rst_n is low.
  - Mux selects take FETCH values.
- First active edge after release performs the FETCH.
- Outputs are Moore, decoded from registered state. AluControl additionally depends combinationally on Instr in EXECUTE states.
- Instruction latency in cycles: data-processing 4, CMP 3, LDR 5, STR 4, B 3, undefined 2.
- A condition that fails suppresses all architectural writes (Reg, Mem, PC-via-Rd/branch, flags). The state sequence is unchanged.
- Flags updated by instruction k are visible to the DECODE of instruction k+1. There is no forwarding inside the same instruction.
- Asserting rst_n low in any state aborts the instruction immediately; no strobe is emitted.

## Structure
- `ctrl_pkg` holds:
  - `state_t` enum (10 states)
  - AluControl encodings
  - cmd codes
  - the 15 Cond codes
  - ALUSrcB/ResultSrc encodings
- Sub-module `cond_logic_module` holds the flag register, the CondEx evaluation and the cond_q latch. It has inputs Cond, ALUFlags, FlagW, flag-enable and DECODE-strobe, and outputs CondEx_q and Flags.
- FSM, ALU decoder and output decode stay in `control_unit_module`.

## Test plan
- Reset, then release; drive ADD (Cond=1110, Op=00, Funct=001000, Rd=0001).
  - Required: states FETCH→DECODE→EXECUTER→ALUWB.
  - RegWrite=1 only in cycle 4; AluControl=00 in EXECUTER; Flags stay 0000 (S=0).
- CMP with ALUFlags=0100.
  - Required: 3 cycles, Flags becomes 0100, RegWrite never asserted.
- Next, BEQ (Cond=0000, Op=10).
  - Required: PCWrite=1 in BRANCH.
  - Repeat after SUBS producing ALUFlags=0000: PCWrite stays 0 in BRANCH.
- LDR (Op=01, Funct[0]=1, Rd=0011).
  - Required: 5 cycles; AdrSrc=1 in MEMREAD; ResultSrc=01 with RegWrite=1 in MEMWB.
  - STR: MemWrite=1 exactly one cycle in MEMWRITE.
- ORRS Rd=1111 with ALUFlags=1000.
  - Required: AluControl=11; PCWrite=1 and RegWrite=0 in ALUWB.
  - Flags N,Z = 10; C,V unchanged.
- rst_n pulsed low during MEMWRITE.
  - Required: MemWrite drops to 0 asynchronously, state returns to FETCH, flags clear to 0000.
